// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with load-use hazard detection
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        id_opcode,
  input  logic [1:0]        id_alu_op,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_2_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_jump,
  input  logic              id_flush,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [3:0]        id_func,
  output logic [1:0]        ex_alu_op,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_2_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic              ex_jump,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [3:0]        ex_func,
  output logic              ex_valid,
  output logic              stall_if,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [6:0]       OP_JUMP   = 7'b1101111;
  localparam logic [6:0]       OP_RTYPE  = 7'b0110011;
  localparam logic [6:0]       OP_BRANCH = 7'b1100011;
  localparam logic [6:0]       OP_STORE  = 7'b0100011;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic use_rs1;
  logic use_rs2;
  logic load_use;
  logic kill;

  always_comb begin
    use_rs1  = (id_opcode != OP_JUMP);
    use_rs2  = (id_opcode == OP_RTYPE) || (id_opcode == OP_BRANCH) ||
               (id_opcode == OP_STORE);
    load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
               ((use_rs1 && (ex_rd == id_rs1)) || (use_rs2 && (ex_rd == id_rs2)));
    kill     = id_flush || load_use;
  end

  // A flushed ID instruction is discarded, so only a genuine load-use holds IF/ID.
  assign stall_if = !id_flush && load_use;

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      ex_alu_op    <= 2'b00;
      ex_branch    <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_2_reg <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_src   <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_jump      <= 1'b0;
      ex_pc        <= '0;
      ex_rdata1    <= '0;
      ex_rdata2    <= '0;
      ex_imm       <= '0;
      ex_rs1       <= 5'd0;
      ex_rs2       <= 5'd0;
      ex_rd        <= 5'd0;
      ex_func      <= 4'd0;
      ex_valid     <= 1'b0;
    end else begin
      ex_alu_op    <= id_alu_op;
      ex_branch    <= id_branch;
      ex_mem_read  <= id_mem_read;
      ex_mem_2_reg <= id_mem_2_reg;
      ex_mem_write <= id_mem_write;
      ex_alu_src   <= id_alu_src;
      ex_reg_write <= id_reg_write;
      ex_jump      <= id_jump;
      ex_pc        <= id_pc;
      ex_rdata1    <= id_rdata1;
      ex_rdata2    <= id_rdata2;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_func      <= id_func;
      ex_valid     <= 1'b1;
    end
  end

  // Flush outranks load-use, so a cycle with both counts only as a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (id_flush) begin
      if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
    end else if (load_use) begin
      if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : directed scoreboard bench for id_ex_stage
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  localparam int DW = 64;
  localparam int CW = 2;

  typedef struct packed {
    logic [1:0]  alu_op;
    logic        branch;
    logic        mem_read;
    logic        mem_2_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic        jump;
    logic [63:0] pc;
    logic [63:0] rdata1;
    logic [63:0] rdata2;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  func;
    logic        valid;
  } ex_t;

  typedef struct packed {
    ex_t         ex;
    logic [CW-1:0] bub;
    logic [CW-1:0] fl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [6:0]    opc;
  logic          flush;
  ex_t           in_b;

  logic [1:0]    ex_alu_op;
  logic          ex_branch, ex_mem_read, ex_mem_2_reg, ex_mem_write;
  logic          ex_alu_src, ex_reg_write, ex_jump, ex_valid, stall_if;
  logic [DW-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [3:0]    ex_func;
  logic [CW-1:0] bubble_cnt, flush_cnt;
  ex_t           obs;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_opcode(opc),
    .id_alu_op(in_b.alu_op), .id_branch(in_b.branch), .id_mem_read(in_b.mem_read),
    .id_mem_2_reg(in_b.mem_2_reg), .id_mem_write(in_b.mem_write),
    .id_alu_src(in_b.alu_src), .id_reg_write(in_b.reg_write), .id_jump(in_b.jump),
    .id_flush(flush), .id_pc(in_b.pc), .id_rdata1(in_b.rdata1), .id_rdata2(in_b.rdata2),
    .id_imm(in_b.imm), .id_rs1(in_b.rs1), .id_rs2(in_b.rs2), .id_rd(in_b.rd),
    .id_func(in_b.func),
    .ex_alu_op(ex_alu_op), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_2_reg(ex_mem_2_reg), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_jump(ex_jump), .ex_pc(ex_pc),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_func(ex_func),
    .ex_valid(ex_valid), .stall_if(stall_if),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  assign obs = {ex_alu_op, ex_branch, ex_mem_read, ex_mem_2_reg, ex_mem_write,
                ex_alu_src, ex_reg_write, ex_jump, ex_pc, ex_rdata1, ex_rdata2,
                ex_imm, ex_rs1, ex_rs2, ex_rd, ex_func, ex_valid};

  ex_t           m_ex;
  logic [CW-1:0] m_bub, m_fl;
  exp_t          q[$];
  int            errors = 0;
  int            checks = 0;
  logic          last_stall;

  task automatic chk(input string tag, input logic [319:0] o, input logic [319:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Decoder-like driver: fills the control bundle the way a control unit would.
  task automatic set_instr(input logic [6:0] o, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic [63:0] imm, input logic [63:0] pc);
    opc         = o;
    in_b        = '0;
    in_b.rs1    = r1;
    in_b.rs2    = r2;
    in_b.rd     = rd;
    in_b.imm    = imm;
    in_b.pc     = pc;
    in_b.rdata1 = pc ^ 64'hDEAD_BEEF_0000_0001;
    in_b.rdata2 = ~pc;
    in_b.func   = 4'(rd) ^ 4'(o[6:4]);
    case (o)
      7'b0000011: begin in_b.mem_read = 1'b1; in_b.mem_2_reg = 1'b1;
                        in_b.alu_src = 1'b1; in_b.reg_write = 1'b1; end
      7'b0010011: begin in_b.alu_src = 1'b1; in_b.reg_write = 1'b1; in_b.alu_op = 2'b10; end
      7'b0110011: begin in_b.reg_write = 1'b1; in_b.alu_op = 2'b10; end
      7'b1100011: begin in_b.branch = 1'b1; in_b.alu_op = 2'b01; end
      7'b0100011: begin in_b.mem_write = 1'b1; in_b.alu_src = 1'b1; end
      7'b1101111: begin in_b.jump = 1'b1; in_b.reg_write = 1'b1; end
      default: ;
    endcase
  endtask

  // One clock: check combinational stall, predict next EX state, compare after the edge.
  task automatic cycle(input bit chk_stall);
    logic u1, u2, lu, es;
    exp_t e;
    u1 = (opc != 7'b1101111);
    u2 = (opc == 7'b0110011) || (opc == 7'b1100011) || (opc == 7'b0100011);
    lu = m_ex.valid && m_ex.mem_read && (m_ex.rd != 5'd0) &&
         ((u1 && (m_ex.rd == in_b.rs1)) || (u2 && (m_ex.rd == in_b.rs2)));
    es = !flush && lu;
    #1;
    last_stall = stall_if;
    if (chk_stall) chk("stall_if", 320'(stall_if), 320'(es));
    if (rst) begin
      m_ex = '0; m_bub = '0; m_fl = '0;
    end else if (flush || lu) begin
      m_ex = '0;
      if (flush) begin
        if (m_fl != '1) m_fl = m_fl + 1'b1;
      end else if (m_bub != '1) begin
        m_bub = m_bub + 1'b1;
      end
    end else begin
      m_ex = in_b;
      m_ex.valid = 1'b1;
    end
    e.ex = m_ex; e.bub = m_bub; e.fl = m_fl;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("ex_bundle", 320'(obs), 320'(e.ex));
    chk("bubble_cnt", 320'(bubble_cnt), 320'(e.bub));
    chk("flush_cnt", 320'(flush_cnt), 320'(e.fl));
  endtask

  initial begin
    m_ex = '0; m_bub = '0; m_fl = '0;
    rst = 1'b1; flush = 1'b0;
    // Reset with nonzero inputs
    set_instr(7'b0000011, 5'd3, 5'd4, 5'd7, 64'h55, 64'h1000);
    cycle(1'b0);
    cycle(1'b1);
    chk("rst_valid", 320'(ex_valid), 320'(0));
    chk("rst_bubble", 320'(bubble_cnt), 320'(0));
    chk("rst_flush", 320'(flush_cnt), 320'(0));
    chk("rst_stall", 320'(stall_if), 320'(0));
    rst = 1'b0;

    // Pass-through
    set_instr(7'b0010011, 5'd1, 5'd2, 5'd5, 64'h10, 64'h40);
    cycle(1'b1);
    chk("pass_rd", 320'(ex_rd), 320'(5));
    chk("pass_imm", 320'(ex_imm), 320'(64'h10));
    chk("pass_pc", 320'(ex_pc), 320'(64'h40));
    chk("pass_alu_src", 320'(ex_alu_src), 320'(1));
    chk("pass_reg_write", 320'(ex_reg_write), 320'(1));
    chk("pass_valid", 320'(ex_valid), 320'(1));

    // Load-use: one stall, one bubble, R-type follows
    set_instr(7'b0000011, 5'd2, 5'd0, 5'd7, 64'h8, 64'h44);
    cycle(1'b1);
    set_instr(7'b0110011, 5'd3, 5'd7, 5'd8, 64'h0, 64'h48);
    cycle(1'b1);
    chk("lu_stall", 320'(last_stall), 320'(1));
    chk("lu_bubble_valid", 320'(ex_valid), 320'(0));
    chk("lu_bubble_rw", 320'(ex_reg_write), 320'(0));
    chk("lu_bubble_cnt", 320'(bubble_cnt), 320'(1));
    cycle(1'b1);
    chk("lu_stall_release", 320'(last_stall), 320'(0));
    chk("lu_rtype_rd", 320'(ex_rd), 320'(8));
    chk("lu_rtype_valid", 320'(ex_valid), 320'(1));

    // No false stalls
    set_instr(7'b0000011, 5'd1, 5'd0, 5'd0, 64'h4, 64'h4C);
    cycle(1'b1);
    set_instr(7'b0110011, 5'd0, 5'd0, 5'd9, 64'h0, 64'h50);
    cycle(1'b1);
    chk("x0_no_stall", 320'(last_stall), 320'(0));
    set_instr(7'b0000011, 5'd1, 5'd0, 5'd7, 64'h4, 64'h54);
    cycle(1'b1);
    set_instr(7'b1101111, 5'd7, 5'd7, 5'd1, 64'h100, 64'h58);
    cycle(1'b1);
    chk("jump_no_stall", 320'(last_stall), 320'(0));
    set_instr(7'b0000011, 5'd1, 5'd0, 5'd7, 64'h4, 64'h5C);
    cycle(1'b1);
    set_instr(7'b0010011, 5'd1, 5'd7, 5'd10, 64'h3, 64'h60);
    cycle(1'b1);
    chk("addi_rs2_no_stall", 320'(last_stall), 320'(0));

    // Flush outranks load-use
    set_instr(7'b0000011, 5'd1, 5'd0, 5'd7, 64'h4, 64'h64);
    cycle(1'b1);
    set_instr(7'b0110011, 5'd7, 5'd7, 5'd11, 64'h0, 64'h68);
    flush = 1'b1;
    cycle(1'b1);
    chk("flush_stall", 320'(last_stall), 320'(0));
    chk("flush_valid", 320'(ex_valid), 320'(0));
    chk("flush_cnt1", 320'(flush_cnt), 320'(1));
    chk("flush_bubble_hold", 320'(bubble_cnt), 320'(1));

    // Saturation at 2^CW-1
    set_instr(7'b1100011, 5'd4, 5'd5, 5'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h6C);
    for (int i = 0; i < 5; i++) cycle(1'b1);
    chk("flush_saturate", 320'(flush_cnt), 320'(3));
    flush = 1'b0;

    // Reset during a load-use stall
    set_instr(7'b0100011, 5'd6, 5'd2, 5'd0, 64'h20, 64'h70);
    cycle(1'b1);
    set_instr(7'b0000011, 5'd1, 5'd0, 5'd7, 64'h4, 64'h74);
    cycle(1'b1);
    set_instr(7'b0110011, 5'd2, 5'd7, 5'd12, 64'h0, 64'h78);
    rst = 1'b1;
    cycle(1'b1);
    chk("rst_mid_stall_seen", 320'(last_stall), 320'(1));
    chk("rst_mid_valid", 320'(ex_valid), 320'(0));
    chk("rst_mid_bubble", 320'(bubble_cnt), 320'(0));
    chk("rst_mid_flush", 320'(flush_cnt), 320'(0));
    rst = 1'b0;
    cycle(1'b1);
    chk("rst_mid_stall_drop", 320'(last_stall), 320'(0));
    chk("rst_mid_rtype_rd", 320'(ex_rd), 320'(12));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
